// File: rtl/xadc_pkg.sv
// rtl/xadc_pkg.sv - shared ADC widths, direction codes and FSM states for the pair filter
package xadc_pkg;

  localparam int ADC_W   = 12;
  localparam int RAW_MSB = 15;
  localparam int RAW_LSB = 4;

  typedef enum logic [1:0] {
    DIR_CENTRE = 2'b00,
    DIR_A      = 2'b01,
    DIR_B      = 2'b10
  } dir_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACCUM = 2'b01,
    DONE  = 2'b10
  } state_e;

  function automatic logic [ADC_W-1:0] raw_of(input logic [15:0] measured);
    return measured[RAW_MSB:RAW_LSB];
  endfunction

endpackage

// File: rtl/xadc_tick_gen.sv
// rtl/xadc_tick_gen.sv - sample-rate tick; counter runs only while EN is high
module xadc_tick_gen #(
  parameter int SAMPLE_DIV = 1000
) (
  input  logic DCLK,
  input  logic RESET,
  input  logic EN,
  output logic TICK
);

  localparam int CW = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLE_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!EN) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge DCLK or posedge RESET) begin
    if (RESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Gated by EN so a stale terminal count cannot tick in the cycle EN drops
  assign TICK = EN && (cnt_q == CNT_LAST);

endmodule

// File: rtl/xadc_pair_filter.sv
// rtl/xadc_pair_filter.sv - decimate and block-average two aux channels, publish A-B and direction
module xadc_pair_filter
  import xadc_pkg::*;
#(
  parameter int SAMPLE_DIV = 1000,
  parameter int AVG_LOG2   = 4,
  parameter int DEADBAND   = 32
) (
  input  logic        DCLK,
  input  logic        RESET,
  input  logic        EN,
  input  logic [15:0] MEASURED_AUX_A,
  input  logic [15:0] MEASURED_AUX_B,
  output logic [11:0] AVG_A,
  output logic [11:0] AVG_B,
  output logic [12:0] DIFF_AB,
  output logic [1:0]  DIR,
  output logic        VALID
);

  localparam int ACC_W = ADC_W + AVG_LOG2;
  localparam logic [AVG_LOG2-1:0] N_LAST = '1;
  localparam logic signed [12:0] DB_POS = 13'(DEADBAND);
  localparam logic signed [12:0] DB_NEG = -DB_POS;

  logic tick;

  xadc_tick_gen #(.SAMPLE_DIV(SAMPLE_DIV)) u_tick (
    .DCLK  (DCLK),
    .RESET (RESET),
    .EN    (EN),
    .TICK  (tick)
  );

  state_e              state_q, state_d;
  logic [ACC_W-1:0]    acc_a_q, acc_a_d, acc_b_q, acc_b_d;
  logic [AVG_LOG2-1:0] n_q, n_d;
  logic [ADC_W-1:0]    avg_a_q, avg_a_d, avg_b_q, avg_b_d;
  logic signed [12:0]  diff_q, diff_d;
  dir_e                dir_q, dir_d;
  logic                valid_q, valid_d;

  logic [ACC_W-1:0]    sum_a, sum_b;
  logic [ADC_W-1:0]    new_avg_a, new_avg_b;
  logic signed [12:0]  new_diff;
  dir_e                new_dir;

  // Block result is built on the final tick so it is visible during the DONE cycle
  always_comb begin
    sum_a     = acc_a_q + ACC_W'(raw_of(MEASURED_AUX_A));
    sum_b     = acc_b_q + ACC_W'(raw_of(MEASURED_AUX_B));
    new_avg_a = ADC_W'(sum_a >> AVG_LOG2);
    new_avg_b = ADC_W'(sum_b >> AVG_LOG2);
    new_diff  = {1'b0, new_avg_a} - {1'b0, new_avg_b};
    if (new_diff > DB_POS) begin
      new_dir = DIR_A;
    end else if (new_diff < DB_NEG) begin
      new_dir = DIR_B;
    end else begin
      new_dir = DIR_CENTRE;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_a_d = acc_a_q;
    acc_b_d = acc_b_q;
    n_d     = n_q;
    avg_a_d = avg_a_q;
    avg_b_d = avg_b_q;
    diff_d  = diff_q;
    dir_d   = dir_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        acc_a_d = '0;
        acc_b_d = '0;
        n_d     = '0;
        if (EN) state_d = ACCUM;
      end
      ACCUM: begin
        if (!EN) begin
          state_d = IDLE;
          acc_a_d = '0;
          acc_b_d = '0;
          n_d     = '0;
        end else if (tick) begin
          if (n_q == N_LAST) begin
            state_d = DONE;
            acc_a_d = '0;
            acc_b_d = '0;
            n_d     = '0;
            avg_a_d = new_avg_a;
            avg_b_d = new_avg_b;
            diff_d  = new_diff;
            dir_d   = new_dir;
            valid_d = 1'b1;
          end else begin
            acc_a_d = sum_a;
            acc_b_d = sum_b;
            n_d     = n_q + 1'b1;
          end
        end
      end
      DONE: begin
        acc_a_d = '0;
        acc_b_d = '0;
        n_d     = '0;
        state_d = EN ? ACCUM : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge DCLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      acc_a_q <= '0;
      acc_b_q <= '0;
      n_q     <= '0;
      avg_a_q <= '0;
      avg_b_q <= '0;
      diff_q  <= '0;
      dir_q   <= DIR_CENTRE;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_a_q <= acc_a_d;
      acc_b_q <= acc_b_d;
      n_q     <= n_d;
      avg_a_q <= avg_a_d;
      avg_b_q <= avg_b_d;
      diff_q  <= diff_d;
      dir_q   <= dir_d;
      valid_q <= valid_d;
    end
  end

  assign AVG_A   = avg_a_q;
  assign AVG_B   = avg_b_q;
  assign DIFF_AB = diff_q;
  assign DIR     = dir_q;
  assign VALID   = valid_q;

endmodule
